// File: rtl/lime_io_bridge.sv
// Host<->core I/O bridge: two first-word-fall-through FIFOs that decouple host
// valid/ready traffic from the core's pop/write strobes, plus sticky error flags.

module BridgeFifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pushReq,
  input  logic                     popReq,
  output logic [WIDTH-1:0]         headData,
  output logic                     notFull,
  output logic                     notEmpty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pushOk, popOk;

  assign notFull  = (count_q < CW'(DEPTH));
  assign notEmpty = (count_q != '0);
  assign count    = count_q;
  assign pushOk   = pushReq && notFull;
  assign popOk    = popReq && notEmpty;
  // Head is masked while empty so stale storage never leaks out.
  assign headData = notEmpty ? mem_q[rdPtr_q] : '0;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = wrPtr_q + AW'(1);
    if (popOk)  rdPtr_d = rdPtr_q + AW'(1);
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset && pushOk) mem_q[wrPtr_q] <= pushData;
  end

endmodule

module lime_io_bridge #(
  parameter int WIDTH     = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [WIDTH-1:0]            host_in_data,
  input  logic                        host_in_valid,
  output logic                        host_in_ready,
  output logic [WIDTH-1:0]            cpu_in_data,
  output logic                        cpu_in_avail,
  input  logic                        cpu_in_pop,
  input  logic [WIDTH-1:0]            cpu_out_data,
  input  logic                        cpu_out_write,
  output logic                        cpu_out_full,
  output logic [WIDTH-1:0]            host_out_data,
  output logic                        host_out_valid,
  input  logic                        host_out_ready,
  input  logic                        err_clr,
  output logic                        overflow_err,
  output logic                        underflow_err,
  output logic [$clog2(IN_DEPTH):0]   in_count,
  output logic [$clog2(OUT_DEPTH):0]  out_count
);

  logic outNotFull;
  logic overflowErr_q, overflowErr_d;
  logic underflowErr_q, underflowErr_d;

  BridgeFifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) inFifo (
    .CLK      (CLK),
    .Reset    (Reset),
    .pushData (host_in_data),
    .pushReq  (host_in_valid),
    .popReq   (cpu_in_pop),
    .headData (cpu_in_data),
    .notFull  (host_in_ready),
    .notEmpty (cpu_in_avail),
    .count    (in_count)
  );

  BridgeFifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) outFifo (
    .CLK      (CLK),
    .Reset    (Reset),
    .pushData (cpu_out_data),
    .pushReq  (cpu_out_write),
    .popReq   (host_out_ready),
    .headData (host_out_data),
    .notFull  (outNotFull),
    .notEmpty (host_out_valid),
    .count    (out_count)
  );

  assign cpu_out_full  = !outNotFull;
  assign overflow_err  = overflowErr_q;
  assign underflow_err = underflowErr_q;

  // A fresh error event outranks a same-cycle clear.
  always_comb begin
    overflowErr_d  = overflowErr_q;
    underflowErr_d = underflowErr_q;
    if (err_clr) begin
      overflowErr_d  = 1'b0;
      underflowErr_d = 1'b0;
    end
    if (cpu_out_write && cpu_out_full) overflowErr_d  = 1'b1;
    if (cpu_in_pop && !cpu_in_avail)   underflowErr_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      overflowErr_q  <= 1'b0;
      underflowErr_q <= 1'b0;
    end else begin
      overflowErr_q  <= overflowErr_d;
      underflowErr_q <= underflowErr_d;
    end
  end

endmodule

// File: tb/tb_lime_io_bridge.sv
// Randomised and directed bench for lime_io_bridge, compared every cycle
// against a queue-based model of the two FIFOs and the sticky flags.

module tb_lime_io_bridge;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [15:0] cpu_in_data;
  logic        cpu_in_avail;
  logic        cpu_in_pop;
  logic [15:0] cpu_out_data;
  logic        cpu_out_write;
  logic        cpu_out_full;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic        err_clr;
  logic        overflow_err;
  logic        underflow_err;
  logic [2:0]  in_count;
  logic [2:0]  out_count;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  logic [15:0] inQ[$];
  logic [15:0] outQ[$];
  bit mUnf = 1'b0;
  bit mOvf = 1'b0;
  bit inPushM, inPopM, outWrM, outRdM;

  lime_io_bridge dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .cpu_in_data    (cpu_in_data),
    .cpu_in_avail   (cpu_in_avail),
    .cpu_in_pop     (cpu_in_pop),
    .cpu_out_data   (cpu_out_data),
    .cpu_out_write  (cpu_out_write),
    .cpu_out_full   (cpu_out_full),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .err_clr        (err_clr),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err),
    .in_count       (in_count),
    .out_count      (out_count)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queues hold the buffered words, flags follow set-beats-clear.
  always @(posedge CLK) begin
    if (!Reset) begin
      inQ.delete();
      outQ.delete();
      mUnf = 1'b0;
      mOvf = 1'b0;
    end else begin
      inPushM = host_in_valid && (inQ.size() < IN_DEPTH);
      inPopM  = cpu_in_pop && (inQ.size() != 0);
      outWrM  = cpu_out_write && (outQ.size() < OUT_DEPTH);
      outRdM  = host_out_ready && (outQ.size() != 0);
      if (err_clr) begin
        mUnf = 1'b0;
        mOvf = 1'b0;
      end
      if (cpu_in_pop && inQ.size() == 0) mUnf = 1'b1;
      if (cpu_out_write && outQ.size() == OUT_DEPTH) mOvf = 1'b1;
      if (inPopM)  void'(inQ.pop_front());
      if (inPushM) inQ.push_back(host_in_data);
      if (outRdM)  void'(outQ.pop_front());
      if (outWrM)  outQ.push_back(cpu_out_data);
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("host_in_ready", 32'(host_in_ready), 32'(inQ.size() < IN_DEPTH));
      checkOutput("cpu_in_avail", 32'(cpu_in_avail), 32'(inQ.size() != 0));
      checkOutput("cpu_in_data", 32'(cpu_in_data), (inQ.size() != 0) ? 32'(inQ[0]) : 32'h0);
      checkOutput("in_count", 32'(in_count), 32'(inQ.size()));
      checkOutput("cpu_out_full", 32'(cpu_out_full), 32'(outQ.size() == OUT_DEPTH));
      checkOutput("host_out_valid", 32'(host_out_valid), 32'(outQ.size() != 0));
      checkOutput("host_out_data", 32'(host_out_data), (outQ.size() != 0) ? 32'(outQ[0]) : 32'h0);
      checkOutput("out_count", 32'(out_count), 32'(outQ.size()));
      checkOutput("underflow_err", 32'(underflow_err), 32'(mUnf));
      checkOutput("overflow_err", 32'(overflow_err), 32'(mOvf));
    end
  end

  task automatic applyStimulus(input logic rstN, input logic hv, input logic [15:0] hd,
                               input logic pop, input logic wr, input logic [15:0] wd,
                               input logic hr, input logic clr);
    Reset          = rstN;
    host_in_valid  = hv;
    host_in_data   = hd;
    cpu_in_pop     = pop;
    cpu_out_write  = wr;
    cpu_out_data   = wd;
    host_out_ready = hr;
    err_clr        = clr;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] drainExp [4];
    int inNext, inRecv, outNext, outRecv;
    logic hv, pop, wr, hr;

    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkEn = 1'b1;
    checkOutput("reset_in_ready", 32'(host_in_ready), 32'h1);
    checkOutput("reset_in_data", 32'(cpu_in_data), 32'h0);
    checkOutput("reset_out_valid", 32'(host_out_valid), 32'h0);

    $display("[TB] fill input FIFO");
    applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("full_in_count", 32'(in_count), 32'd4);
    checkOutput("full_in_ready", 32'(host_in_ready), 32'h0);
    checkOutput("full_head", 32'(cpu_in_data), 32'h1111);
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("fifth_push_count", 32'(in_count), 32'd4);

    $display("[TB] push+pop while full, then drain");
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("full_pushpop_count", 32'(in_count), 32'd3);
    checkOutput("full_pushpop_head", 32'(cpu_in_data), 32'h2222);
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("refill_count", 32'(in_count), 32'd4);
    drainExp = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_in", 32'(cpu_in_data), 32'(drainExp[i]));
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    end
    checkOutput("drained_avail", 32'(cpu_in_avail), 32'h0);

    $display("[TB] pop on empty with same-cycle push");
    applyStimulus(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("underflow_set", 32'(underflow_err), 32'h1);
    checkOutput("underflow_count", 32'(in_count), 32'd1);
    checkOutput("underflow_head", 32'(cpu_in_data), 32'hABCD);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("underflow_clr", 32'(underflow_err), 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    $display("[TB] output FIFO overflow");
    for (int i = 1; i <= 5; i++)
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
    checkOutput("out_full", 32'(cpu_out_full), 32'h1);
    checkOutput("overflow_set", 32'(overflow_err), 32'h1);
    checkOutput("overflow_count", 32'(out_count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_out", 32'(host_out_data), 32'(i));
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    end
    checkOutput("out_drained", 32'(host_out_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    $display("[TB] wrap-around streaming");
    inNext = 0; inRecv = 0; outNext = 0; outRecv = 0;
    for (int i = 0; i < 40; i++) begin
      hv  = (inNext < 10);
      pop = cpu_in_avail && (inRecv < 10);
      wr  = (outNext < 10) && !cpu_out_full;
      hr  = i[0];
      if (pop) begin
        checkOutput("wrap_in_order", 32'(cpu_in_data), 32'h0A00 + 32'(inRecv));
        inRecv++;
      end
      if (hr && host_out_valid) begin
        checkOutput("wrap_out_order", 32'(host_out_data), 32'h0B00 + 32'(outRecv));
        outRecv++;
      end
      applyStimulus(1'b1, hv, 16'h0A00 + 16'(inNext), pop, wr, 16'h0B00 + 16'(outNext), hr, 1'b0);
      if (hv && inNext < 10 && vectors > 0) begin end
      checkOutput("wrap_in_bound", 32'(in_count <= 3'd4), 32'h1);
      checkOutput("wrap_out_bound", 32'(out_count <= 3'd4), 32'h1);
      if (hv) inNext = inNext + 1 - ((in_count == 3'd4 && !pop) ? 0 : 0);
      if (wr) outNext++;
    end
    checkOutput("wrap_in_total", 32'(inRecv), 32'd10);
    checkOutput("wrap_out_total", 32'(outRecv), 32'd10);

    $display("[TB] reset with buffered words");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
    checkOutput("pre_reset_in", 32'(in_count), 32'd3);
    checkOutput("pre_reset_out", 32'(out_count), 32'd3);
    applyStimulus(1'b0, 1'b1, 16'hEEEE, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    checkOutput("rst_in_count", 32'(in_count), 32'd0);
    checkOutput("rst_out_count", 32'(out_count), 32'd0);
    checkOutput("rst_out_valid", 32'(host_out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(host_out_data), 32'h0);
    checkOutput("rst_unf", 32'(underflow_err), 32'h0);
    checkOutput("rst_ovf", 32'(overflow_err), 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++)
      applyStimulus($urandom_range(0, 63) != 0, 1'($urandom), 16'($urandom), 1'($urandom),
                    1'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
